// File: rtl/spi_reg_bridge.sv
// SPI-slave register bridge: an oversampled SPI frame is a header word (op + address)
// followed by auto-incrementing read or write data words against status/command registers.
module spi_reg_bridge #(
  parameter int                        DATA_W   = 16,
  parameter int                        ADDR_W   = 10,
  parameter int                        NUM_STAT = 23,
  parameter int                        NUM_CMD  = 16,
  parameter logic [1:0]                SPI_MODE = 2'd0,
  parameter logic [DATA_W-1:0]         ID_WORD  = 16'h4A53,
  parameter logic [NUM_CMD*DATA_W-1:0] CMD_RST  = '0
) (
  input  logic                         SYS_CLK,
  input  logic                         SYS_RST,
  input  logic                         SPI_CLK,
  input  logic                         SSEL,
  input  logic                         MOSI,
  output logic                         MISO,
  input  logic [NUM_STAT*DATA_W-1:0]   status_in,
  output logic [NUM_CMD*DATA_W-1:0]    cmd_out,
  output logic [NUM_CMD-1:0]           cmd_wr,
  output logic                         xfer_active,
  output logic [7:0]                   err_cnt,
  output logic [2:0]                   dbg_state
);

  localparam int   CMD_BASE = NUM_STAT + 1;
  localparam int   CNT_W    = $clog2(DATA_W);
  localparam logic CPOL     = SPI_MODE[1];
  localparam logic CPHA     = SPI_MODE[0];
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_READ, S_WRITE, S_DISCARD} state_e;

  state_e                       state_q, state_d;
  logic [2:0]                   sclk_q, sclk_d;
  logic [2:0]                   ssel_q, ssel_d;
  logic [1:0]                   mosi_q, mosi_d;
  logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]            rx_q, rx_d;
  logic [DATA_W-1:0]            tx_q, tx_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [NUM_STAT*DATA_W-1:0]   snap_q, snap_d;
  logic [NUM_CMD*DATA_W-1:0]    cmd_q, cmd_d;
  logic [NUM_CMD-1:0]           cmd_wr_q, cmd_wr_d;
  logic [7:0]                   err_q, err_d;

  logic              sclk_rise, sclk_fall, sample_edge, shift_edge;
  logic              ssel_fall, ssel_rise, in_frame, word_done;
  logic [DATA_W-1:0] rx_word, rd_data;
  logic [ADDR_W-1:0] rd_addr;

  assign sclk_d = {sclk_q[1:0], SPI_CLK};
  assign ssel_d = {ssel_q[1:0], SSEL};
  assign mosi_d = {mosi_q[0], MOSI};

  // Stage 1 vs stage 2 of each chain gives the edge; MOSI stage 1 lines up with SPI_CLK stage 1.
  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign sample_edge = (CPHA ^ CPOL) ? sclk_fall : sclk_rise;
  assign shift_edge  = (CPHA ^ CPOL) ? sclk_rise : sclk_fall;
  assign ssel_fall   = ssel_q[2] & ~ssel_q[1];
  assign ssel_rise   = ~ssel_q[2] & ssel_q[1];
  assign in_frame    = (state_q != S_IDLE);
  assign rx_word     = {rx_q[DATA_W-2:0], mosi_q[1]};
  assign word_done   = in_frame && sample_edge && (bit_cnt_q == LAST_BIT);
  assign rd_addr     = (state_q == S_HEADER) ? rx_word[ADDR_W-1:0] : addr_q;

  always_comb begin
    rd_data = '0;
    if (rd_addr == '0) rd_data = ID_WORD;
    for (int i = 0; i < NUM_STAT; i++)
      if (rd_addr == ADDR_W'(i + 1)) rd_data = snap_q[i*DATA_W +: DATA_W];
    for (int i = 0; i < NUM_CMD; i++)
      if (rd_addr == ADDR_W'(CMD_BASE + i)) rd_data = cmd_q[i*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    snap_d    = snap_q;
    cmd_d     = cmd_q;
    cmd_wr_d  = '0;
    err_d     = err_q;
    if (ssel_fall) begin
      snap_d    = status_in;
      tx_d      = ID_WORD;
      bit_cnt_d = '0;
      rx_d      = '0;
      state_d   = S_HEADER;
    end else if (in_frame) begin
      if (sample_edge) begin
        rx_d      = rx_word;
        bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
      end else if (shift_edge && bit_cnt_q != '0) begin
        // The first shift edge of a word is skipped: its MSB is already on MISO.
        tx_d = {tx_q[DATA_W-2:0], 1'b0};
      end
      if (word_done) begin
        tx_d = '0;
        case (state_q)
          S_HEADER: begin
            case (rx_word[DATA_W-1 -: 2])
              2'b10: begin
                state_d = S_READ;
                tx_d    = rd_data;
                addr_d  = rx_word[ADDR_W-1:0] + 1'b1;
              end
              2'b01: begin
                state_d = S_WRITE;
                addr_d  = rx_word[ADDR_W-1:0];
              end
              default: state_d = S_DISCARD;
            endcase
          end
          S_READ: begin
            tx_d   = rd_data;
            addr_d = addr_q + 1'b1;
          end
          S_WRITE: begin
            for (int i = 0; i < NUM_CMD; i++)
              if (addr_q == ADDR_W'(CMD_BASE + i)) begin
                cmd_d[i*DATA_W +: DATA_W] = rx_word;
                cmd_wr_d[i]               = 1'b1;
              end
            addr_d = addr_q + 1'b1;
          end
          default: ;
        endcase
      end
      // A word completing on the same cycle as deselect has already been handled above.
      if (ssel_rise) begin
        if (bit_cnt_d != '0 && err_q != 8'hFF) err_d = err_q + 8'd1;
        state_d   = S_IDLE;
        tx_d      = '0;
        bit_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q   <= S_IDLE;
      sclk_q    <= {3{CPOL}};
      ssel_q    <= '1;
      mosi_q    <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      snap_q    <= '0;
      cmd_q     <= CMD_RST;
      cmd_wr_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      ssel_q    <= ssel_d;
      mosi_q    <= mosi_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      snap_q    <= snap_d;
      cmd_q     <= cmd_d;
      cmd_wr_q  <= cmd_wr_d;
      err_q     <= err_d;
    end
  end

  assign MISO        = tx_q[DATA_W-1];
  assign cmd_out     = cmd_q;
  assign cmd_wr      = cmd_wr_q;
  assign err_cnt     = err_q;
  assign xfer_active = ~ssel_q[1];
  assign dbg_state   = state_q;

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Parametrised SPI-slave register bridge between the host SPI master and fabric status/command registers; runs on SYS_CLK with oversampled SPI_CLK/SSEL/MOSI.
- Word width, register counts and SPI mode are generic; supports multi-word read and write bursts with auto-increment.
- Adds per-register write strobes, coherent status snapshots per frame and a framing-error counter.

Parameters:
- DATA_W, 16, SPI word width and register width (≥12).
- ADDR_W, 10, address field width; DATA_W-2 ≥ ADDR_W.
- NUM_STAT, 23, read-only status registers.
- NUM_CMD, 16, read/write command registers.
- SPI_MODE, 0, standard modes 0-3 (bit1 = CPOL, bit0 = CPHA).
- ID_WORD, 16'h4A53, constant returned at address 0 and shifted out during the header word.
- CMD_RST, all-zero NUM_CMD*DATA_W vector, command reset values.

Ports:
- SYS_CLK  in  1  system clock, ≥8× SPI_CLK.
- SYS_RST  in  1  asynchronous active-high reset.
- SPI_CLK  in  1  SPI clock, asynchronous.
- SSEL  in  1  slave select, active low, asynchronous.
- MOSI  in  1  master data in.
- MISO  out  1  slave data out.
- status_in  in  NUM_STAT*DATA_W  status words; reg i = bits [i*DATA_W +: DATA_W].
- cmd_out  out  NUM_CMD*DATA_W  command register contents.
- cmd_wr  out  NUM_CMD  one-cycle pulse per command register written.
- xfer_active  out  1  high while synchronised SSEL is low.
- err_cnt  out  8  count of aborted frames, saturating.

Behaviour:
- Reset (asynchronous, active-high SYS_RST): cmd_out = CMD_RST; cmd_wr = 0; err_cnt = 0; xfer_active = 0; MISO = 0; FSM = IDLE; bit counter = 0.
- Synchronisation: 3-flop chains on SPI_CLK and SSEL; 2 flops on MOSI. Edges are detected from the synchronised signals.
- Edge selection: the leading edge is rising when CPOL=0, falling when CPOL=1.
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
- Bit order: MSB first on both MOSI and MISO.
- Address map:
  - 0 = ID_WORD.
  - 1..NUM_STAT = status.
  - CMD_BASE = NUM_STAT+1 .. CMD_BASE+NUM_CMD-1 = command registers.
  - All other addresses read 0 and ignore writes.
- Address register: ADDR_W bits, increments modulo 2^ADDR_W.
- Frame start (SSEL falling, synchronised):
  - Snapshot all of status_in into a shadow register; every status read in the frame returns the snapshot.
  - Load the MISO shifter with ID_WORD; bit counter = 0; FSM = HEADER.
- HEADER state: on word completion, decode op = word[DATA_W-1:DATA_W-2] and addr = word[ADDR_W-1:0].
  - 2'b10 → READ.
  - 2'b01 → WRITE.
  - 2'b00 or 2'b11 → DISCARD.
- READ state:
  - After each completed word, load the shifter with reg[addr], then addr += 1.
  - Word k (k ≥ 1) carries reg[hdr_addr + k - 1].
  - Words received on MOSI are ignored.
  - Reload completes within 3 SYS_CLK cycles of the sampling edge, before the next shift edge.
- WRITE state:
  - On each completed word, if addr is in the command range: cmd_out[addr-CMD_BASE] updates on the next SYS_CLK and cmd_wr bit pulses that same cycle; then addr += 1.
  - Addresses out of range advance addr with no effect.
  - MISO shifts zeros.
- DISCARD state: all words ignored; MISO = 0.
- Frame end (SSEL rising):
  - If the bit counter ≠ 0, the partial word is dropped (no write, no strobe) and err_cnt += 1, saturating at 255.
  - FSM → IDLE; MISO = 0.
- Simultaneous events: SSEL rising in the same cycle as word completion → the completed word is processed; no error is counted.
- Reset during a frame: FSM returns to IDLE. The frame resumes only at the next SSEL falling edge.
- MISO is always driven; it is 0 while idle.

Test Plan:
1. Mode 0 read: header 16'h8001, then 3 dummy words, status_in reg0=0x0123, reg1=0x0045, reg2=0x03FF → MISO words: 0x4A53, 0x0123, 0x0045, 0x03FF.
2. Burst write: header 16'h4018 (addr 24 = CMD_BASE), then 0x0600, 0x0700 → cmd_out[0]=0x0600, cmd_out[1]=0x0700; cmd_wr pulses 0x0001 then 0x0002, one cycle each; a readback at 0x8018 returns 0x0600, 0x0700.
3. Abort: SSEL rises after 9 bits of the second write word → cmd_out unchanged, no cmd_wr pulse, err_cnt = 1. Run 300 aborts → err_cnt = 255.
4. Snapshot: status reg0 changes 0x0011 → 0x0022 mid-burst → every read of reg0 in that frame returns 0x0011; the next frame returns 0x0022.
5. Modes 1/2/3 repeat scenario 1 with matching master timing → identical data; out-of-range read at address 0x3FF returns 0 and the address wraps to 0, returning ID_WORD.
6. Assert SYS_RST mid-write burst → cmd_out = CMD_RST immediately; after release, a new frame with header 0x8000 returns 0x4A53 first.
